// File: rtl/cdf_builder.sv
// cdf_builder: scans NBINS histogram bins from an external RAM, accumulates a
// saturating cumulative count, and streams it to a downstream divider.
// Ports:
//   clk, reset (async, active-low), enable (run gate), start (scan request)
//   hist_data  - RAM read data, valid one cycle after hist_rd_en
//   hist_addr, hist_rd_en - RAM read address / strobe
//   div_en     - divider start pulse, one cycle ahead of the first cdf_out
//   cdf_out, cdf_valid - cumulative count (saturated at 255) and its strobe
//   cdf_min    - first non-zero cdf_out of the scan
//   busy, done - scan in progress / end-of-scan pulse
module cdf_builder #(
   parameter int unsigned NBINS = 16,
   parameter int unsigned AW    = 4
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          enable,
   input  logic          start,
   input  logic [7:0]    hist_data,
   output logic [AW-1:0] hist_addr,
   output logic          hist_rd_en,
   output logic          div_en,
   output logic [7:0]    cdf_out,
   output logic          cdf_valid,
   output logic [7:0]    cdf_min,
   output logic          busy,
   output logic          done
);

   localparam int unsigned SW = 9;

   typedef enum logic [1:0] {IDLE, READ, DRAIN, FINISH} state_t;

   state_t        state, state_nx;
   logic [AW-1:0] addr_r;
   logic          rd_r;
   logic          pend_r;
   logic          valid_r;
   logic          div_r;
   logic          done_r;
   logic [SW-1:0] acc_r;
   logic [7:0]    cdf_r;
   logic [7:0]    min_r;

   logic          last_rd_c;
   logic [SW-1:0] sum_c;
   logic [SW-1:0] sat_c;

   assign last_rd_c = (addr_r == AW'(NBINS - 1));
   // acc_r never exceeds 255, so the 9-bit sum cannot overflow.
   assign sum_c     = acc_r + SW'(hist_data);
   assign sat_c     = (sum_c > SW'(255)) ? SW'(255) : sum_c;

   // Next-state logic.
   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (start) state_nx = READ;
         READ:    if (last_rd_c) state_nx = DRAIN;
         // Last value is on cdf_out once nothing is left in the read pipe.
         DRAIN:   if (valid_r && !pend_r) state_nx = FINISH;
         FINISH:  state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // State register; a low enable freezes the FSM.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)      state <= IDLE;
      else if (enable) state <= state_nx;
   end

   // Read sequencer, accumulator and output registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         addr_r  <= '0;
         rd_r    <= 1'b0;
         pend_r  <= 1'b0;
         valid_r <= 1'b0;
         div_r   <= 1'b0;
         done_r  <= 1'b0;
         acc_r   <= '0;
         cdf_r   <= '0;
         min_r   <= '0;
      end else if (enable) begin
         // pend_r marks that hist_data carries the bin read last cycle.
         pend_r  <= (state == READ);
         valid_r <= pend_r;
         div_r   <= 1'b0;
         done_r  <= (state == DRAIN) && (state_nx == FINISH);

         if (state == IDLE && start) begin
            addr_r <= '0;
            rd_r   <= 1'b1;
            acc_r  <= '0;
            min_r  <= '0;
         end

         if (state == READ) begin
            div_r <= (addr_r == '0);
            if (last_rd_c) begin
               addr_r <= '0;
               rd_r   <= 1'b0;
            end else begin
               addr_r <= addr_r + AW'(1);
            end
         end

         if (pend_r) begin
            acc_r <= sat_c;
            cdf_r <= sat_c[7:0];
            // The sum is monotonic, so a zero min means none captured yet.
            if (min_r == '0) min_r <= sat_c[7:0];
         end
      end
   end

   // Strobes are suppressed while stalled so the RAM and divider see no
   // spurious or duplicated events.
   assign hist_addr  = addr_r;
   assign hist_rd_en = rd_r & enable;
   assign div_en     = div_r & enable;
   assign cdf_valid  = valid_r & enable;
   assign done       = done_r & enable;
   assign cdf_out    = cdf_r;
   assign cdf_min    = min_r;
   assign busy       = (state != IDLE);

endmodule

// File: doc/cdf_builder.md
CDF_BUILDER -- requirements
Module: cdf_builder

Interface
REQ-001 Parameter: NBINS, 16, number of histogram bins (gray levels) scanned per run.
REQ-002 Parameter: AW, 4, histogram address width, with 2**AW = NBINS.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 enable  input  1  global run gate; low freezes the block.
REQ-006 start  input  1  one-cycle request to begin a CDF scan; sampled in IDLE only.
REQ-007 hist_data  input  8  bin count returned by histogram RAM one cycle after hist_rd_en.
REQ-008 hist_addr  output  AW  bin address presented to histogram RAM.
REQ-009 hist_rd_en  output  1  histogram RAM read strobe.
REQ-010 div_en  output  1  one-cycle pulse to the downstream divider; precedes the first cdf_out by exactly one cycle.
REQ-011 cdf_out  output  8  cumulative count, saturated at 255, feeds divider cdf_in.
REQ-012 cdf_valid  output  1  cdf_out holds a new value this cycle.
REQ-013 cdf_min  output  8  first non-zero cdf_out of the current scan.
REQ-014 busy  output  1  high in any state other than IDLE.
REQ-015 done  output  1  one-cycle pulse after the last cdf_valid.

Function
REQ-016 FSM states: IDLE, READ, DRAIN, FINISH.
- IDLE -> READ: on start=1 with enable=1.
- READ -> DRAIN: after the read of address NBINS-1 is issued.
- DRAIN -> FINISH: when the last accumulated value is output.
- FINISH -> IDLE: unconditional, after one cycle.
REQ-017 Timing (scan start = cycle 0, enable high throughout):
- Read of bin k: hist_rd_en=1, hist_addr=k in cycle 1+k, k = 0..NBINS-1.
- hist_data for bin k: sampled in cycle 2+k.
- cdf_out/cdf_valid for bin k: registered, visible in cycle 3+k.
REQ-018 div_en is high in cycle 2 only. With NBINS=16, cdf_valid is high in cycles 3..18, done is high in cycle 19, and the FSM is in IDLE in cycle 20.
REQ-019 Accumulator:
- 9-bit internal running sum, cleared at each scan start.
- sum(k) = sum(k-1) + hist_data(k).
- cdf_out = 255 when sum(k) > 255, otherwise sum(k).
- Once the sum saturates, it holds at the saturated value for the rest of the scan.
REQ-020 cdf_min:
- Cleared to 0 at scan start.
- Captured from the first cdf_out value that is non-zero; unchanged for the rest of the scan.
- Remains 0 if every bin is zero.
- Holds its value after done until the next scan starts.
REQ-021 cdf_out holds its last value when cdf_valid is low.
REQ-022 start while busy=1 is ignored, with no effect on the scan in progress.
REQ-023 enable low, in any state:
- All registers hold.
- hist_rd_en, div_en, cdf_valid and done are forced to 0.
- On return of enable, the scan resumes exactly where it stopped, with no lost or duplicated bin.
- The histogram RAM holds hist_data stable while hist_rd_en is low.
REQ-024 hist_addr is 0 outside READ.

Reset
REQ-025 reset low asynchronously forces the following, including mid-scan:
- State IDLE.
- hist_addr=0, accumulator=0, cdf_out=0, cdf_min=0.
- hist_rd_en=0, div_en=0, cdf_valid=0, busy=0, done=0.
REQ-026 After reset is released, no output changes until a new start is accepted; no partial scan resumes.

Verification
REQ-027 All bins=1, start pulse:
- div_en in cycle 2.
- cdf_out = 1,2,...,16 in cycles 3..18.
- cdf_min=1, done in cycle 19.
REQ-028 Bins 0..2 = 0, bin 3 = 4, remaining bins = 2:
- cdf_out = 0,0,0,4,6,...,28.
- cdf_min=4.
REQ-029 All bins=32:
- cdf_out = 32,64,...,224, then 255 from bin 7 through bin 15.
- No wrap to a small value.
REQ-030 enable dropped for 5 cycles during cycle 6 of a scan with all bins=3:
- The cdf_out sequence is 3,6,...,48 with no gap or repeat.
- done is delayed by exactly 5 cycles.
REQ-031 start pulsed again in cycle 8 of a scan: ignored; a single done pulse is produced.
REQ-032 reset asserted in cycle 10 of a scan:
- All outputs return to 0 immediately, busy=0.
- A subsequent start with all bins=1 gives cdf_out = 1..16 and cdf_min=1.
